// File: rtl/ddc_pkg.sv
// Shared DDC chain definitions: CIC stage count, rate limits, accumulator
// width derivation and the rate-to-gain-shift table for the CIC decimator.
package ddc_pkg;

  localparam int unsigned CIC_N         = 4;
  localparam int unsigned CIC_MAXRATE   = 255;
  localparam int unsigned CIC_RATE_BITS = 8;
  // Worst-case bit growth: N stages of log2(256) bits each.
  localparam int unsigned CIC_GROWTH    = CIC_N * CIC_RATE_BITS;
  localparam int unsigned CIC_SHIFT_W   = 6;
  localparam int unsigned CIC_TAB_BITS  = (CIC_MAXRATE + 1) * CIC_SHIFT_W;

  typedef logic [CIC_SHIFT_W-1:0]   cic_shift_t;
  typedef logic [CIC_RATE_BITS-1:0] cic_rate_t;

  function automatic int unsigned cic_accw(input int unsigned width);
    return width + CIC_GROWTH;
  endfunction

  // Entry r holds ceil(4*log2(r)), i.e. the smallest s with 2^s >= r^4.
  // Entry 0 mirrors entry 1 because a rate of 0 runs as rate 1.
  function automatic logic [CIC_TAB_BITS-1:0] cic_build_shift_tab();
    logic [CIC_TAB_BITS-1:0] tab;
    longint unsigned rr;
    longint unsigned p;
    int unsigned     s;
    tab = '0;
    s   = 0;
    for (int unsigned r = 1; r <= CIC_MAXRATE; r++) begin
      rr = 64'(r);
      p  = rr * rr * rr * rr;
      // s is monotonic in r, so it is carried across iterations.
      while ((64'd1 << s) < p) s++;
      tab[r*CIC_SHIFT_W +: CIC_SHIFT_W] = CIC_SHIFT_W'(s);
    end
    return tab;
  endfunction

  localparam logic [CIC_TAB_BITS-1:0] CIC_SHIFT_TAB = cic_build_shift_tab();

  function automatic cic_shift_t cic_shift(input cic_rate_t rate);
    return CIC_SHIFT_TAB[int'(rate)*CIC_SHIFT_W +: CIC_SHIFT_W];
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: registered difference against the previous accepted
// sample, advancing only on its strobe, with the strobe re-timed alongside.
module cic_comb_stage #(
  parameter int unsigned W = 56
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         stb,
  input  logic [W-1:0] sample,
  output logic         stb_next,
  output logic [W-1:0] diff
);

  logic [W-1:0] dly;

  // Differentiate on strobe; the strobe itself always moves one cycle on.
  always_ff @(posedge clk) begin
    if (!rst || !run) begin
      stb_next <= 1'b0;
      diff     <= '0;
      dly      <= '0;
    end else begin
      stb_next <= stb;
      if (stb) begin
        diff <= sample - dly;
        dly  <= sample;
      end
    end
  end

endmodule

// File: rtl/cic_dec.sv
// Programmable-rate 4-stage CIC decimator (rate 1..255) with rate-dependent
// gain normalisation; one strobed output per decimated sample, 6 cycles
// after the decimating input strobe.
module cic_dec
  import ddc_pkg::*;
#(
  parameter int unsigned IWIDTH = 16,
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned N      = CIC_N,
  parameter int unsigned ACCW   = cic_accw(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [7:0]        rate,
  input  logic              stb_in,
  input  logic [IWIDTH-1:0] data_in,
  output logic              stb_out,
  output logic [WIDTH-1:0]  data_out
);

  localparam int unsigned PIPE = N + 2;

  logic              clear;
  logic [ACCW-1:0]   x;
  logic [ACCW-1:0]   integ [N];
  logic [7:0]        cnt;
  logic              stb_c0;
  logic              stb_c1;
  logic [ACCW-1:0]   cap;
  logic              stb_stage [N];
  logic [ACCW-1:0]   comb_q    [N];
  cic_shift_t        sh_pipe   [PIPE];

  always_comb begin
    clear = !rst || !run;
    // Sign-extend, then place the sample at the top of the output width.
    x = ACCW'($signed(data_in)) << (WIDTH - IWIDTH);
  end

  // Integrator chain: each stage accumulates the previous stage's old value.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned k = 0; k < N; k++) integ[k] <= '0;
    end else if (stb_in) begin
      integ[0] <= integ[0] + x;
      for (int unsigned k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  // Frame counter: rate is sampled only when the counter reloads.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt    <= '0;
      stb_c0 <= 1'b0;
    end else begin
      stb_c0 <= 1'b0;
      if (stb_in) begin
        if (cnt == 8'd0) begin
          cnt    <= (rate == 8'd0) ? 8'd0 : rate - 8'd1;
          stb_c0 <= 1'b1;
        end else begin
          cnt <= cnt - 8'd1;
        end
      end
    end
  end

  // Gain shift rides alongside the strobe so back-to-back outputs at
  // differing rates each use the shift chosen at their own reload.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned k = 0; k < PIPE; k++) sh_pipe[k] <= '0;
    end else begin
      sh_pipe[0] <= cic_shift(rate);
      for (int unsigned k = 1; k < PIPE; k++) sh_pipe[k] <= sh_pipe[k-1];
    end
  end

  // Capture the last integrator at the decimation instant.
  always_ff @(posedge clk) begin
    if (clear) begin
      stb_c1 <= 1'b0;
      cap    <= '0;
    end else begin
      stb_c1 <= stb_c0;
      if (stb_c0) cap <= integ[N-1];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_comb
    if (g == 0) begin : g_first
      cic_comb_stage #(.W(ACCW)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .stb      (stb_c1),
        .sample   (cap),
        .stb_next (stb_stage[g]),
        .diff     (comb_q[g])
      );
    end else begin : g_rest
      cic_comb_stage #(.W(ACCW)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .stb      (stb_stage[g-1]),
        .sample   (comb_q[g-1]),
        .stb_next (stb_stage[g]),
        .diff     (comb_q[g])
      );
    end
  end

  // Normalise gain by truncating shift; hold the sample between strobes.
  always_ff @(posedge clk) begin
    if (clear) begin
      stb_out  <= 1'b0;
      data_out <= '0;
    end else begin
      stb_out <= stb_stage[N-1];
      if (stb_stage[N-1]) data_out <= WIDTH'(comb_q[N-1] >> sh_pipe[PIPE-1]);
    end
  end

endmodule

// File: tb/tb_cic_dec.sv
// Self-checking bench for cic_dec: a cumulative-sum / binomial-difference
// model of the CIC predicts every cycle's stb_out and data_out.
module tb_cic_dec;

  logic        clk;
  logic        rst;
  logic        run;
  logic [7:0]  rate;
  logic        stb_in;
  logic [15:0] data_in;
  logic        stb_out;
  logic [23:0] data_out;

  cic_dec #(.IWIDTH(16), .WIDTH(24)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .rate     (rate),
    .stb_in   (stb_in),
    .data_in  (data_in),
    .stb_out  (stb_out),
    .data_out (data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  typedef struct { longint at; logic [23:0] val; } ev_t;
  ev_t         evq[$];
  longint      edge_no = 0;
  longint      s1, s2, s3, s4;
  longint      h [3];
  longint      vh [5];
  int          to_go;
  logic        exp_stb;
  logic [23:0] exp_data;

  function automatic int ref_shift(input logic [7:0] r);
    longint unsigned rr, p;
    int s;
    rr = (r == 8'd0) ? 64'd1 : 64'(r);
    p  = rr * rr * rr * rr;
    s  = 0;
    while ((64'd1 << s) < p) s++;
    return s;
  endfunction

  task automatic model_clear();
    evq.delete();
    s1 = 0; s2 = 0; s3 = 0; s4 = 0;
    for (int i = 0; i < 3; i++) h[i] = 0;
    for (int i = 0; i < 5; i++) vh[i] = 0;
    to_go    = 0;
    exp_stb  = 1'b0;
    exp_data = '0;
  endtask

  // i3 after sample n equals the 4th running sum taken 3 samples earlier;
  // the output is the 4th finite difference of those decimated values.
  task automatic model_sample(input logic [15:0] d, input logic [7:0] r);
    longint x, v, y;
    ev_t ev;
    x = longint'($signed(d)) <<< 8;
    v = h[2];
    s1 += x; s2 += s1; s3 += s2; s4 += s3;
    h[2] = h[1]; h[1] = h[0]; h[0] = s4;
    if (to_go == 0) begin
      for (int i = 4; i > 0; i--) vh[i] = vh[i-1];
      vh[0] = v;
      y = vh[0] - 4 * vh[1] + 6 * vh[2] - 4 * vh[3] + vh[4];
      y = (y <<< 8) >>> 8;
      ev.at  = edge_no + 6;
      ev.val = 24'(y >>> ref_shift(r));
      evq.push_back(ev);
      to_go = (r == 8'd0) ? 0 : int'(r) - 1;
    end else begin
      to_go--;
    end
  endtask

  task automatic tick(input logic r_rst, input logic r_run, input logic r_stb,
                      input logic [7:0] r_rate, input logic [15:0] d);
    rst = r_rst; run = r_run; stb_in = r_stb; rate = r_rate; data_in = d;
    @(posedge clk);
    edge_no++;
    if (!r_rst || !r_run) begin
      model_clear();
    end else begin
      if (evq.size() > 0 && evq[0].at == edge_no) begin
        exp_stb  = 1'b1;
        exp_data = evq[0].val;
        void'(evq.pop_front());
      end else begin
        exp_stb = 1'b0;
      end
      if (r_stb) model_sample(d, r_rate);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, 1'b1, 1'b1, 8'd4, 16'h1234);
      n_cmp++;
      if (stb_out !== 1'b0 || data_out !== 24'd0) begin
        n_bad++;
        $display("FAIL reset c%0d: stb_out=%0b data_out=%0d want 0/0", c, stb_out, data_out);
      end
    end
  endtask

  task automatic test_rate1_ramp();
    tick(1'b0, 1'b1, 1'b0, 8'd1, 16'd0);
    for (int c = 0; c < 48; c++) begin
      tick(1'b1, 1'b1, c < 40, 8'd1, 16'(c));
      n_cmp++;
      if (stb_out !== exp_stb || data_out !== exp_data) begin
        n_bad++;
        $display("FAIL ramp c%0d: got stb=%0b data=%0d want stb=%0b data=%0d",
                 c, stb_out, $signed(data_out), exp_stb, $signed(exp_data));
      end
    end
  endtask

  task automatic test_rate4_const();
    logic [23:0] last;
    int t_prev, t_last;
    last = '0; t_prev = 0; t_last = 0;
    tick(1'b0, 1'b1, 1'b0, 8'd4, 16'd0);
    for (int c = 0; c < 136; c++) begin
      tick(1'b1, 1'b1, (c % 2 == 0) && (c < 128), 8'd4, 16'd1000);
      n_cmp++;
      if (stb_out !== exp_stb || data_out !== exp_data) begin
        n_bad++;
        $display("FAIL rate4 c%0d: got stb=%0b data=%0d want stb=%0b data=%0d",
                 c, stb_out, $signed(data_out), exp_stb, $signed(exp_data));
      end
      if (stb_out === 1'b1) begin last = data_out; t_prev = t_last; t_last = c; end
    end
    n_cmp++;
    if (last !== 24'd256000) begin
      n_bad++;
      $display("FAIL rate4_steady: got %0d want 256000", $signed(last));
    end
    n_cmp++;
    if (t_last - t_prev != 8) begin
      n_bad++;
      $display("FAIL rate4_spacing: got %0d cycles want 8", t_last - t_prev);
    end
  endtask

  task automatic test_rate5_const();
    logic [23:0] last;
    last = '0;
    tick(1'b0, 1'b1, 1'b0, 8'd5, 16'd0);
    for (int c = 0; c < 160; c++) begin
      tick(1'b1, 1'b1, (c % 3 == 0) && (c < 150), 8'd5, 16'd1024);
      n_cmp++;
      if (stb_out !== exp_stb || data_out !== exp_data) begin
        n_bad++;
        $display("FAIL rate5 c%0d: got stb=%0b data=%0d want stb=%0b data=%0d",
                 c, stb_out, $signed(data_out), exp_stb, $signed(exp_data));
      end
      if (stb_out === 1'b1) last = data_out;
    end
    n_cmp++;
    if (last !== 24'd160000) begin
      n_bad++;
      $display("FAIL rate5_steady: got %0d want 160000", $signed(last));
    end
  endtask

  task automatic test_rate255_extremes();
    logic [23:0] last;
    last = '0;
    tick(1'b0, 1'b1, 1'b0, 8'd255, 16'd0);
    for (int c = 0; c < 3070; c++) begin
      tick(1'b1, 1'b1, c < 3060, 8'd255, (c < 1530) ? 16'h8000 : 16'h7fff);
      n_cmp++;
      if (stb_out !== exp_stb || data_out !== exp_data) begin
        n_bad++;
        $display("FAIL rate255 c%0d: got stb=%0b data=%0d want stb=%0b data=%0d",
                 c, stb_out, $signed(data_out), exp_stb, $signed(exp_data));
      end
      if (stb_out === 1'b1) last = data_out;
    end
    n_cmp++;
    if (last !== 24'd8258049) begin
      n_bad++;
      $display("FAIL rate255_pos: got %0d want 8258049", $signed(last));
    end
  endtask

  task automatic test_run_abort();
    logic [7:0] r;
    int seen;
    seen = 0;
    tick(1'b0, 1'b1, 1'b0, 8'd4, 16'd0);
    for (int c = 0; c < 60; c++) begin
      r = (c < 14) ? 8'd4 : 8'd2;
      // Run drops right after the decimating sample at c=8.
      tick(1'b1, c != 9, 1'b1, r, 16'(100 + 7 * c));
      n_cmp++;
      if (stb_out !== exp_stb || data_out !== exp_data) begin
        n_bad++;
        $display("FAIL abort c%0d: got stb=%0b data=%0d want stb=%0b data=%0d",
                 c, stb_out, $signed(data_out), exp_stb, $signed(exp_data));
      end
      if (c >= 9 && c <= 15 && stb_out === 1'b1) seen++;
    end
    // Restart at c=10 decimates immediately; its output lands at c=16.
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL abort_discard: got %0d strobes want 0", seen);
    end
  endtask

  task automatic test_reset_inflight();
    int hits, nonzero;
    hits = 0; nonzero = 0;
    tick(1'b0, 1'b1, 1'b0, 8'd1, 16'd0);
    for (int c = 0; c < 8; c++) tick(1'b1, 1'b1, 1'b1, 8'd1, 16'd3000);
    tick(1'b0, 1'b1, 1'b1, 8'd1, 16'd3000);
    n_cmp++;
    if (stb_out !== 1'b0 || data_out !== 24'd0) begin
      n_bad++;
      $display("FAIL inflight_rst: got stb=%0b data=%0d want 0/0", stb_out, $signed(data_out));
    end
    for (int c = 0; c < 20; c++) begin
      tick(1'b1, 1'b1, 1'b1, 8'd1, (c == 0) ? 16'd1 : 16'd0);
      n_cmp++;
      if (stb_out !== exp_stb || data_out !== exp_data) begin
        n_bad++;
        $display("FAIL impulse c%0d: got stb=%0b data=%0d want stb=%0b data=%0d",
                 c, stb_out, $signed(data_out), exp_stb, $signed(exp_data));
      end
      if (stb_out === 1'b1 && data_out == 24'd256) hits++;
      if (stb_out === 1'b1 && data_out != 24'd0) nonzero++;
    end
    n_cmp++;
    if (hits != 1 || nonzero != 1) begin
      n_bad++;
      $display("FAIL impulse_count: got %0d/%0d want 1/1", hits, nonzero);
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic       rn;
    r = 8'd3;
    tick(1'b0, 1'b1, 1'b0, r, 16'd0);
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 49) == 0) r = 8'($urandom_range(0, 12));
      rn = ($urandom_range(0, 79) != 0);
      tick(1'b1, rn, $urandom_range(0, 2) != 0, r, 16'($urandom));
      n_cmp++;
      if (stb_out !== exp_stb || data_out !== exp_data) begin
        n_bad++;
        $display("FAIL random c%0d: got stb=%0b data=%0d want stb=%0b data=%0d",
                 c, stb_out, $signed(data_out), exp_stb, $signed(exp_data));
      end
    end
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; rate = 8'd1; stb_in = 1'b0; data_in = '0;
    model_clear();
    test_reset();
    test_rate1_ramp();
    test_rate4_const();
    test_rate5_const();
    test_rate255_extremes();
    test_run_abort();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
